// File: rtl/keypad_digit_entry.sv
// Keypad entry buffer: debounces one-hot keypad codes and assembles accepted
// digits into an N-slot BCD display word, with clear/backspace/enter handling.
module keypad_digit_entry #(
  parameter int NUM_DIGITS    = 3,
  parameter int STABLE_CYCLES = 4,
  parameter int FILL_MODE     = 0,
  localparam int CW = $clog2(NUM_DIGITS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [15:0]             onehot,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [CW-1:0]           count,
  output logic                    full,
  output logic [3:0]              cur_code,
  output logic                    key_event,
  output logic                    entered,
  output logic                    overflow,
  output logic [1:0]              state_dbg
);

  localparam int DW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [3:0] BLANK = 4'hF;
  localparam logic [3:0] K_CLR = 4'hA;
  localparam logic [3:0] K_BSP = 4'hB;
  localparam logic [3:0] K_ENT = 4'hE;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

  state_t          state_q, state_n;
  logic [DW-1:0]   cnt_q, cnt_n;
  logic [3:0]      cand_q, cand_n;
  logic            key_valid;
  logic [3:0]      key_code;
  logic            accept;
  logic [3:0]      acc_code;

  logic [3:0]      slot_q [NUM_DIGITS];
  logic [3:0]      slot_n [NUM_DIGITS];
  logic [CW-1:0]   count_q, count_n;
  logic [3:0]      code_q, code_n;
  logic            post_q, post_n;
  logic            ev_q, ev_n, ent_q, ent_n, ovf_q, ovf_n;

  // Only listed single-bit codes are keys; every other pattern reads as "no key".
  always_comb begin
    key_valid = 1'b1;
    key_code  = BLANK;
    unique case (onehot)
      16'h0008: key_code = 4'd0;
      16'h0080: key_code = 4'd1;
      16'h0040: key_code = 4'd2;
      16'h0020: key_code = 4'd3;
      16'h0800: key_code = 4'd4;
      16'h0400: key_code = 4'd5;
      16'h0200: key_code = 4'd6;
      16'h8000: key_code = 4'd7;
      16'h4000: key_code = 4'd8;
      16'h2000: key_code = 4'd9;
      16'h0001: key_code = K_CLR;
      16'h0002: key_code = K_BSP;
      16'h0004: key_code = K_ENT;
      default:  key_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= BLANK;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      cand_q  <= cand_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    cand_n   = cand_q;
    accept   = 1'b0;
    acc_code = cand_q;
    unique case (state_q)
      IDLE: begin
        if (key_valid) begin
          cand_n = key_code;
          if (STABLE_CYCLES == 1) begin
            accept   = 1'b1;
            acc_code = key_code;
            state_n  = HELD;
            cnt_n    = '0;
          end else begin
            cnt_n   = DW'(1);
            state_n = DEBOUNCE;
          end
        end
      end
      DEBOUNCE: begin
        if (key_valid && key_code == cand_q) begin
          if (cnt_q == DW'(STABLE_CYCLES - 1)) begin
            accept  = 1'b1;
            state_n = HELD;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q + DW'(1);
          end
        end else begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      HELD: begin
        // A different key while held is ignored until a full release.
        if (!key_valid) begin
          if (STABLE_CYCLES == 1) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            state_n = RELEASE;
            cnt_n   = DW'(1);
          end
        end
      end
      RELEASE: begin
        if (key_valid) begin
          state_n = HELD;
          cnt_n   = '0;
        end else if (cnt_q == DW'(STABLE_CYCLES - 1)) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + DW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    slot_n  = slot_q;
    count_n = count_q;
    code_n  = code_q;
    post_n  = post_q;
    ev_n    = 1'b0;
    ent_n   = 1'b0;
    ovf_n   = 1'b0;
    if (accept) begin
      code_n = acc_code;
      ev_n   = 1'b1;
      unique case (acc_code)
        K_CLR: begin
          for (int i = 0; i < NUM_DIGITS; i++) slot_n[i] = BLANK;
          count_n = '0;
        end
        K_BSP: begin
          if (count_q != '0) begin
            if (FILL_MODE == 0) begin
              for (int i = 0; i < NUM_DIGITS; i++)
                if ((CW'(i) + CW'(1)) == count_q) slot_n[i] = BLANK;
            end else begin
              for (int i = 0; i < NUM_DIGITS - 1; i++) slot_n[i] = slot_q[i+1];
              slot_n[NUM_DIGITS-1] = BLANK;
            end
            count_n = count_q - CW'(1);
          end
        end
        K_ENT: begin
          if (count_q != '0) begin
            ent_n  = 1'b1;
            post_n = 1'b1;
          end
        end
        default: begin
          // First digit after a completed entry starts a fresh number.
          if (post_q) begin
            for (int i = 0; i < NUM_DIGITS; i++) slot_n[i] = BLANK;
            slot_n[0] = acc_code;
            count_n   = CW'(1);
            post_n    = 1'b0;
          end else if (FILL_MODE == 0) begin
            if (count_q < CW'(NUM_DIGITS)) begin
              for (int i = 0; i < NUM_DIGITS; i++)
                if (CW'(i) == count_q) slot_n[i] = acc_code;
              count_n = count_q + CW'(1);
            end else begin
              ovf_n = 1'b1;
            end
          end else begin
            for (int i = 1; i < NUM_DIGITS; i++) slot_n[i] = slot_q[i-1];
            slot_n[0] = acc_code;
            if (count_q == CW'(NUM_DIGITS)) ovf_n = 1'b1;
            else count_n = count_q + CW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) slot_q[i] <= BLANK;
      count_q <= '0;
      code_q  <= BLANK;
      post_q  <= 1'b0;
      ev_q    <= 1'b0;
      ent_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) slot_q[i] <= slot_n[i];
      count_q <= count_n;
      code_q  <= code_n;
      post_q  <= post_n;
      ev_q    <= ev_n;
      ent_q   <= ent_n;
      ovf_q   <= ovf_n;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digits
    assign digits[4*g +: 4] = slot_q[g];
  end

  assign count     = count_q;
  assign full      = (count_q == CW'(NUM_DIGITS));
  assign cur_code  = code_q;
  assign key_event = ev_q;
  assign entered   = ent_q;
  assign overflow  = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Bench for keypad_digit_entry: one fixed-slot and one shift-left instance,
// directed key sequences with hand-computed expected buffer states.
module tb_keypad_digit_entry;

  localparam int W = 21;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] oh0, oh1;
  logic [11:0] digits0, digits1;
  logic [1:0]  count0, count1;
  logic        full0, full1;
  logic [3:0]  code0, code1;
  logic        ev0, ev1, ent0, ent1, ovf0, ovf1;
  logic [1:0]  st0, st1;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int n_checks = 0;
  int n_fail   = 0;

  keypad_digit_entry #(.NUM_DIGITS(3), .STABLE_CYCLES(4), .FILL_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .onehot(oh0), .digits(digits0), .count(count0),
    .full(full0), .cur_code(code0), .key_event(ev0), .entered(ent0),
    .overflow(ovf0), .state_dbg(st0));

  keypad_digit_entry #(.NUM_DIGITS(3), .STABLE_CYCLES(4), .FILL_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .onehot(oh1), .digits(digits1), .count(count1),
    .full(full1), .cur_code(code1), .key_event(ev1), .entered(ent1),
    .overflow(ovf1), .state_dbg(st1));

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s act=%h req=%h", name, act, req);
    end
  endtask

  // packed view: {digits, count, cur_code, entered, overflow, full}
  function automatic logic [W-1:0] pk(input logic [11:0] d, input logic [1:0] c,
                                      input logic [3:0] k, input logic e, input logic o);
    return {d, c, k, e, o, (c == 2'd3)};
  endfunction

  // driver tasks
  task automatic drive(input int m, input logic [15:0] v, input int n);
    if (m == 0) oh0 = v; else oh1 = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int m, input int b, input logic [W-1:0] e);
    logic [15:0] v;
    v = '0;
    v[b] = 1'b1;
    if (m == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
    drive(m, v, 6);
    drive(m, 16'h0, 6);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n) begin
      if (ev0) begin
        if (exp_q0.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL ev0_unexpected act=%h req=none", {digits0, count0, code0, ent0, ovf0, full0});
        end else begin
          e = exp_q0.pop_front();
          chk("ev0", 32'({digits0, count0, code0, ent0, ovf0, full0}), 32'(e));
        end
      end else if (ent0 || ovf0) begin
        chk("pulse0_without_event", 32'({ent0, ovf0}), 32'h0);
      end
      if (ev1) begin
        if (exp_q1.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL ev1_unexpected act=%h req=none", {digits1, count1, code1, ent1, ovf1, full1});
        end else begin
          e = exp_q1.pop_front();
          chk("ev1", 32'({digits1, count1, code1, ent1, ovf1, full1}), 32'(e));
        end
      end else if (ent1 || ovf1) begin
        chk("pulse1_without_event", 32'({ent1, ovf1}), 32'h0);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    oh0 = '0;
    oh1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_digits0", 32'(digits0), 32'hFFF);
    chk("rst_count0", 32'(count0), 32'd0);
    chk("rst_code0", 32'(code0), 32'hF);
    chk("rst_flags0", 32'({full0, ev0, ent0, ovf0}), 32'h0);
    chk("rst_digits1", 32'(digits1), 32'hFFF);
    rst_n = 1'b1;
    drive(0, 16'h0, 2);

    // fixed-slot fill, overflow, backspace, clear
    press(0, 7, pk(12'hFF1, 2'd1, 4'd1, 1'b0, 1'b0));
    press(0, 6, pk(12'hF21, 2'd2, 4'd2, 1'b0, 1'b0));
    press(0, 5, pk(12'h321, 2'd3, 4'd3, 1'b0, 1'b0));
    chk("full_after_3", 32'({digits0, count0, full0}), 32'({12'h321, 2'd3, 1'b1}));
    press(0, 15, pk(12'h321, 2'd3, 4'd7, 1'b0, 1'b1));
    press(0, 1, pk(12'hF21, 2'd2, 4'hB, 1'b0, 1'b0));
    press(0, 0, pk(12'hFFF, 2'd0, 4'hA, 1'b0, 1'b0));
    press(0, 1, pk(12'hFFF, 2'd0, 4'hB, 1'b0, 1'b0));

    // debounce: short glitch, long hold, key change while held, non-keys
    drive(0, 16'h0080, 3);
    drive(0, 16'h0, 6);
    chk("glitch_no_change", 32'({digits0, count0}), 32'({12'hFFF, 2'd0}));
    exp_q0.push_back(pk(12'hFF1, 2'd1, 4'd1, 1'b0, 1'b0));
    drive(0, 16'h0080, 20);
    drive(0, 16'h0, 6);
    exp_q0.push_back(pk(12'hF11, 2'd2, 4'd1, 1'b0, 1'b0));
    drive(0, 16'h0080, 6);
    drive(0, 16'h0040, 6);
    drive(0, 16'h0, 6);
    chk("switch_held_one_insert", 32'({digits0, count0}), 32'({12'hF11, 2'd2}));
    drive(0, 16'h0010, 8);
    drive(0, 16'h0, 6);
    drive(0, 16'h0088, 8);
    drive(0, 16'h0, 6);
    chk("non_keys_ignored", 32'({digits0, count0}), 32'({12'hF11, 2'd2}));

    // enter handling
    press(0, 0, pk(12'hFFF, 2'd0, 4'hA, 1'b0, 1'b0));
    press(0, 10, pk(12'hFF5, 2'd1, 4'd5, 1'b0, 1'b0));
    press(0, 9, pk(12'hF65, 2'd2, 4'd6, 1'b0, 1'b0));
    press(0, 2, pk(12'hF65, 2'd2, 4'hE, 1'b1, 1'b0));
    press(0, 13, pk(12'hFF9, 2'd1, 4'd9, 1'b0, 1'b0));
    press(0, 0, pk(12'hFFF, 2'd0, 4'hA, 1'b0, 1'b0));
    press(0, 2, pk(12'hFFF, 2'd0, 4'hE, 1'b0, 1'b0));
    press(0, 11, pk(12'hFF4, 2'd1, 4'd4, 1'b0, 1'b0));

    // shift-left mode
    press(1, 7, pk(12'hFF1, 2'd1, 4'd1, 1'b0, 1'b0));
    press(1, 6, pk(12'hF12, 2'd2, 4'd2, 1'b0, 1'b0));
    press(1, 5, pk(12'h123, 2'd3, 4'd3, 1'b0, 1'b0));
    press(1, 11, pk(12'h234, 2'd3, 4'd4, 1'b0, 1'b1));
    press(1, 1, pk(12'hF23, 2'd2, 4'hB, 1'b0, 1'b0));
    press(1, 2, pk(12'hF23, 2'd2, 4'hE, 1'b1, 1'b0));
    press(1, 15, pk(12'hFF7, 2'd1, 4'd7, 1'b0, 1'b0));

    // reset in the middle of debounce
    press(0, 0, pk(12'hFFF, 2'd0, 4'hA, 1'b0, 1'b0));
    press(0, 7, pk(12'hFF1, 2'd1, 4'd1, 1'b0, 1'b0));
    press(0, 6, pk(12'hF21, 2'd2, 4'd2, 1'b0, 1'b0));
    drive(0, 16'h0020, 2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_clears", 32'({digits0, count0, full0}), 32'({12'hFFF, 2'd0, 1'b0}));
    chk("async_rst_mode1", 32'({digits1, count1}), 32'({12'hFFF, 2'd0}));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q0.push_back(pk(12'hFF3, 2'd1, 4'd3, 1'b0, 1'b0));
    drive(0, 16'h0020, 3);
    chk("post_rst_not_yet", 32'({count0, ev0}), 32'h0);
    drive(0, 16'h0020, 1);
    chk("post_rst_accept", 32'({digits0, count0, ev0}), 32'({12'hFF3, 2'd1, 1'b1}));
    drive(0, 16'h0, 8);

    chk("q0_drained", 32'(exp_q0.size()), 32'd0);
    chk("q1_drained", 32'(exp_q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
